// File: rtl/alu_add_sequencer.sv
// Round-robin two-requester front end for the shared 8-bit ALU adder.
// Wide add/subtract is sequenced one byte per cycle, LSB first, carry rippled through a register.
module alu_add_sequencer #(
    parameter int NBYTES = 2,
    localparam int W = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_sub,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_sub,
    output logic [7:0]   add_a,
    output logic [7:0]   add_b,
    output logic         add_cin,
    input  logic [7:0]   add_sum,
    input  logic         add_cout,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_result,
    output logic         rsp_cout,
    output logic         rsp_ovf
);

    // Handshakes: a transfer happens on the rising edge where valid && ready are both high.
    // Requesters hold a/b/sub stable while valid && !ready; the consumer sees rsp_* frozen
    // while rsp_valid && !rsp_ready.

    localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   ptr;
    logic [KW-1:0]          k;
    logic                   carry;
    logic [NBYTES-1:0][7:0] a_q;
    logic [NBYTES-1:0][7:0] b_q;
    logic [NBYTES-1:0][7:0] res_q;
    logic                   sub_q;
    logic                   id_q;
    logic                   ovf_q;
    logic                   grant1;
    logic                   accept;
    logic                   last_byte;
    logic                   a_top;
    logic                   b_eff_top;

    // Requester 1 wins when it is alone or when both are valid and the pointer favours it.
    assign grant1    = req1_valid && (!req0_valid || ptr);
    assign accept    = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign last_byte = (k == KW'(NBYTES - 1));
    assign a_top     = a_q[NBYTES-1][7];
    assign b_eff_top = b_q[NBYTES-1][7] ^ sub_q;

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        add_a      = 8'd0;
        add_b      = 8'd0;
        add_cin    = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = rst_n && req0_valid && !grant1;
                req1_ready = rst_n && grant1;
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                add_a   = a_q[k];
                add_b   = b_q[k] ^ {8{sub_q}};
                add_cin = (k == '0) ? sub_q : carry;
                if (last_byte) state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 1'b0;
            carry <= 1'b0;
            k     <= '0;
            id_q  <= 1'b0;
            ovf_q <= 1'b0;
            res_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        k    <= '0;
                        id_q <= req1_ready;
                    end
                end
                RUN: begin
                    res_q[k] <= add_sum;
                    carry    <= add_cout;
                    k        <= last_byte ? '0 : k + 1'b1;
                    // add_sum here is the top result byte, so its MSB is the result sign.
                    if (last_byte) ovf_q <= (a_top == b_eff_top) && (add_sum[7] != a_top);
                end
                RESP: begin
                    if (rsp_ready) ptr <= ~id_q;
                end
                default: ;
            endcase
        end
    end

    // Operand capture needs no reset: it is only read in RUN, which always follows a capture.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q   <= req1_ready ? req1_a : req0_a;
            b_q   <= req1_ready ? req1_b : req0_b;
            sub_q <= req1_ready ? req1_sub : req0_sub;
        end
    end

    assign rsp_valid  = (state == RESP);
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_cout   = carry;
    assign rsp_ovf    = ovf_q;

endmodule
